// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding and legal WIDTH range.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_adder_pkg;

    // Legal operand width range for serial_adder_seq
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half adders and an OR of their carries.
// Latency: combinational.
// Backpressure: none.
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    // First stage adds the operand bits
    half_adder u_ha0 (
        .i_a (i_a),
        .i_b (i_b),
        .o_s (ha0_s),
        .o_c (ha0_c)
    );

    // Second stage folds in the incoming carry
    half_adder u_ha1 (
        .i_a (ha0_s),
        .i_b (i_c),
        .o_s (o_s),
        .o_c (ha1_c)
    );

    // At most one of the two half-adder carries can be set
    assign o_c = ha0_c | ha1_c;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder: sum = a ^ b, carry = a & b.
// Latency: combinational.
// Backpressure: none.
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: latches A/B on start, adds LSB-first one bit per clock.
// Latency: result and o_done appear WIDTH edges after the accepted start edge.
// Backpressure: i_start ignored while o_busy; optional SERIAL_ADDER_SUB_EN adds i_sub (A-B).
module serial_adder_seq
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_busy,
    output logic             o_done
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Reject illegal widths at elaboration
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_adder_seq: WIDTH out of range");
    end

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [WIDTH-1:0] sum_sr_q,  sum_sr_d;
    logic             c_q,       c_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] o_sum_q,   o_sum_d;
    logic             o_carry_q, o_carry_d;

    logic [WIDTH-1:0] b_load;
    logic             c_init;
    logic             fa_s;
    logic             fa_c;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1: invert B on load and preset the carry
    assign b_load = i_sub ? ~i_b : i_b;
    assign c_init = i_sub;
`else
    assign b_load = i_b;
    assign c_init = 1'b0;
`endif

    // Per-bit adder fed from the shift-register LSBs and the carry flop
    full_adder_cell u_fa (
        .i_a (a_q[0]),
        .i_b (b_q[0]),
        .i_c (c_q),
        .o_s (fa_s),
        .o_c (fa_c)
    );

    // Next-state logic: load on start, shift one bit per cycle, publish on last bit
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_sr_d  = sum_sr_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        o_sum_d   = o_sum_q;
        o_carry_d = o_carry_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    a_d      = i_a;
                    b_d      = b_load;
                    c_d      = c_init;
                    sum_sr_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                c_d      = fa_c;
                sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Outputs only change here, so a reset can never expose a partial sum
                    o_sum_d   = {fa_s, sum_sr_q[WIDTH-1:1]};
                    o_carry_d = fa_c;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_sr_q  <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            o_sum_q   <= '0;
            o_carry_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_sr_q  <= sum_sr_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            o_sum_q   <= o_sum_d;
            o_carry_q <= o_carry_d;
        end
    end

    assign o_sum   = o_sum_q;
    assign o_carry = o_carry_q;
    assign o_busy  = (state_q != ST_IDLE);
    assign o_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_adder_seq.sv
// Randomized scoreboard bench for serial_adder_seq against an arithmetic reference.
// Latency: expects o_done exactly WIDTH edges after each accepted start.
// Backpressure: starts during an operation are expected to be dropped.
module tb_serial_adder_seq;

    localparam int W = 4;

    logic         i_clk   = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic         i_sub   = 1'b0;
    logic [W-1:0] i_a     = '0;
    logic [W-1:0] i_b     = '0;
    logic [W-1:0] o_sum;
    logic         o_carry;
    logic         o_busy;
    logic         o_done;

    serial_adder_seq #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
`ifdef SERIAL_ADDER_SUB_EN
        .i_sub   (i_sub),
`endif
        .i_a     (i_a),
        .i_b     (i_b),
        .o_sum   (o_sum),
        .o_carry (o_carry),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        int           done_edge;
    } exp_t;

    exp_t         sb_q[$];
    int           edge_no    = 0;
    int           next_free  = 0;
    int           last_e0    = -1000;
    logic [W-1:0] last_sum   = '0;
    logic         last_carry = 1'b0;
    int           errors     = 0;
    int           checks     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Reference: plain integer arithmetic, modulo 2^W with the carry reported separately
    function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sub, input int done_edge);
        exp_t           e;
        longint unsigned av;
        longint unsigned bv;
        longint unsigned r;
        av = longint'(a);
        bv = longint'(b);
        if (sub) begin
            r       = av - bv;
            e.carry = (av >= bv);
        end else begin
            r       = av + bv;
            e.carry = r[W];
        end
        e.sum       = r[W-1:0];
        e.done_edge = done_edge;
        return e;
    endfunction

    // Acceptance model: a start is taken only once the previous op has fully retired
    always @(posedge i_clk) begin
        edge_no++;
        if (i_rst_n && i_start && edge_no >= next_free) begin
            sb_q.push_back(ref_op(i_a, i_b, i_sub, edge_no + W));
            last_e0   = edge_no;
            next_free = edge_no + W + 2;
        end
    end

    // Reset discards any operation in flight and the last published result
    always @(negedge i_rst_n) begin
        sb_q.delete();
        next_free  = 0;
        last_e0    = -1000;
        last_sum   = '0;
        last_carry = 1'b0;
    end

    // Monitor: compare status every cycle and pop the scoreboard on each done pulse
    always @(posedge i_clk) begin
        exp_t e;
        int   rel;
        #1;
        if (!i_rst_n) begin
            chk("rst_busy",  o_busy,  0);
            chk("rst_done",  o_done,  0);
            chk("rst_sum",   o_sum,   0);
            chk("rst_carry", o_carry, 0);
        end else begin
            rel = edge_no - last_e0;
            chk("busy", o_busy, (rel >= 0 && rel <= W));
            chk("done", o_done, (rel == W));
            if (o_done) begin
                if (sb_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_edge", e.done_edge, edge_no);
                    last_sum   = e.sum;
                    last_carry = e.carry;
                end
            end
            chk("sum",   o_sum,   last_sum);
            chk("carry", o_carry, last_carry);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        @(negedge i_clk);
        i_start = 1'b1;
        i_a     = a;
        i_b     = b;
`ifdef SERIAL_ADDER_SUB_EN
        i_sub   = sub;
`else
        i_sub   = 1'b0 & sub;
`endif
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        i_rst_n = 1'b1;

        // Basic add and carry boundaries
        go(4'h5, 4'h3, 1'b0); idle(W + 2);
        go(4'hF, 4'h1, 1'b0); idle(W + 2);
        go(4'hF, 4'hF, 1'b0); idle(W + 2);
        go(4'h0, 4'h0, 1'b0); idle(W + 2);

        // Start while busy is dropped
        go(4'h2, 4'h2, 1'b0); idle(1);
        go(4'h7, 4'h7, 1'b0); idle(W + 2);

        // Operand change after the start edge has no effect
        go(4'h1, 4'h1, 1'b0);
        i_a = 4'hF;
        idle(W + 2);

        // Reset mid-operation aborts immediately
        go(4'h9, 4'h9, 1'b0); idle(1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("abort_busy",  o_busy,  0);
        chk("abort_done",  o_done,  0);
        chk("abort_sum",   o_sum,   0);
        chk("abort_carry", o_carry, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        go(4'h9, 4'h9, 1'b0); idle(W + 2);

`ifdef SERIAL_ADDER_SUB_EN
        go(4'h5, 4'h3, 1'b1); idle(W + 2);
        go(4'h3, 4'h5, 1'b1); idle(W + 2);
`endif

        // Start held high: back-to-back operations with changing operands
        @(negedge i_clk);
        i_start = 1'b1;
        repeat (3 * (W + 2) + 1) begin
            @(negedge i_clk);
            i_a = W'($urandom);
            i_b = W'($urandom);
        end
        i_start = 1'b0;
        idle(W + 3);

        // Random start pulses, operands and (if present) subtract mode
        repeat (400) begin
            @(negedge i_clk);
            i_start = ($urandom_range(0, 2) == 0);
            i_a     = W'($urandom);
            i_b     = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            i_sub   = $urandom_range(0, 1) == 1;
`endif
        end
        i_start = 1'b0;
        idle(W + 4);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
